// File: rtl/posit_normalize_product_es3.sv
// posit_normalize_product_es3
//   Packs a raw, unrounded posit product (sign, scale, MSB-aligned fraction,
//   inf/zero flags) into a 32-bit ES=3 posit. The packing includes
//   regime/exponent encoding, round-to-nearest-even with sticky, saturation
//   to maxpos/minpos, and the two's-complement sign.
//   Three register stages: input capture, regime packing, rounding/output.
//
// Ports
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   start    : input word valid this cycle
//   in       : serialized value_product word (see posit_es3_pkg)
//   result   : encoded posit
//   done     : result valid (start delayed by 3 cycles)
//   inf      : result is NaR
//   zero     : result is zero (never set together with inf)

package posit_es3_pkg;
  localparam int NBITS = 32;
  localparam int ES    = 3;
  localparam int SBITS = 10;
  localparam int MBITS = 56;
  localparam int POSIT_SERIALIZED_WIDTH_PRODUCT_ES3 = 3 + SBITS + MBITS;

  typedef struct packed {
    logic             inf;
    logic             zero;
    logic             sgn;
    logic [SBITS-1:0] scale;
    logic [MBITS-1:0] frac;
  } value_product_t;

  function automatic value_product_t deserialize_prod(
    input logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] bits
  );
    return value_product_t'(bits);
  endfunction
endpackage

module posit_normalize_product_es3 #(
  parameter int NBITS    = posit_es3_pkg::NBITS,
  parameter int ES       = posit_es3_pkg::ES,
  parameter int SBITS    = posit_es3_pkg::SBITS,
  parameter int MBITS    = posit_es3_pkg::MBITS,
  parameter int MAXSCALE = (NBITS - 2) * (2 ** ES)
) (
  input  logic                                                   clk,
  input  logic                                                   reset_n,
  input  logic                                                   start,
  input  logic [posit_es3_pkg::POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] in,
  output logic [NBITS-1:0]                                       result,
  output logic                                                   done,
  output logic                                                   inf,
  output logic                                                   zero
);

  localparam int FW = 2 * NBITS;          // regime/exponent/fraction field
  localparam int PW = 2 + ES + MBITS;     // seed pattern before regime expansion
  localparam int WW = PW + FW;            // room for the widest regime shift
  localparam int KW = SBITS - ES;         // width of the regime value k
  localparam logic signed [SBITS-1:0] MAX_S = SBITS'(MAXSCALE);
  localparam logic signed [SBITS-1:0] MIN_S = SBITS'(-MAXSCALE);
  localparam logic [NBITS-2:0] MAG_ONES = '1;
  localparam logic [NBITS-2:0] MAG_ONE  = (NBITS-1)'(1);

  // ---------------- Stage 0: capture ----------------
  posit_es3_pkg::value_product_t s0_vp_q;
  logic                          s0_valid_q;

  // ---------------- Stage 1: regime packing ----------------
  logic [NBITS-2:0] s1_kept_q, s1_kept_d;
  logic             s1_guard_q, s1_guard_d;
  logic             s1_sticky_q, s1_sticky_d;
  logic             s1_sgn_q, s1_sat_max_q, s1_sat_min_q, s1_sat_max_d, s1_sat_min_d;
  logic             s1_inf_q, s1_zero_q;
  logic             s1_valid_q;

  logic signed [SBITS-1:0] scale_s;
  logic [KW-1:0]           k;
  logic                    k_neg;
  logic [KW-1:0]           run_sh;
  logic [PW-1:0]           pattern;
  logic [WW-1:0]           wide, shifted;
  logic [FW-1:0]           field;

  // Regime expansion trick: the seed starts with "10" (k>=0) or "01" (k<0)
  // and an arithmetic right shift replicates the leading bit. Shifting by k
  // gives k+1 ones then a zero; shifting by -k-1 (= ~k) gives -k zeros then
  // a one. Saturated scales produce a meaningless field that stage 2 ignores.
  // NOTE: combinational blocks use blocking assignments and give every output
  // a value on every path, so no latch can be inferred.
  always_comb begin
    scale_s      = $signed(s0_vp_q.scale);
    k            = s0_vp_q.scale[SBITS-1:ES];
    k_neg        = k[KW-1];
    run_sh       = k_neg ? ~k : k;
    pattern      = {~k_neg, k_neg, s0_vp_q.scale[ES-1:0], s0_vp_q.frac};
    wide         = {pattern, {FW{1'b0}}};
    shifted      = $unsigned($signed(wide) >>> run_sh);
    field        = shifted[WW-1 -: FW];
    s1_kept_d    = field[FW-1 -: NBITS-1];
    s1_guard_d   = field[FW-NBITS];
    s1_sticky_d  = (|field[FW-NBITS-1:0]) | (|shifted[WW-FW-1:0]);
    s1_sat_max_d = (scale_s >= MAX_S);
    s1_sat_min_d = (scale_s <= MIN_S);
  end

  // ---------------- Stage 2: rounding and output ----------------
  logic             round_up;
  logic [NBITS-1:0] mag_sum;
  logic [NBITS-2:0] mag, mag_neg;
  logic [NBITS-1:0] result_d;

  always_comb begin
    round_up = s1_guard_q & (s1_sticky_q | s1_kept_q[0]);
    mag_sum  = {1'b0, s1_kept_q} + NBITS'(round_up);
    // Rounding may not carry past maxpos, nor may a nonzero value land on 0.
    mag      = mag_sum[NBITS-1] ? MAG_ONES : mag_sum[NBITS-2:0];
    if (mag == '0)   mag = MAG_ONE;
    if (s1_sat_max_q) mag = MAG_ONES;
    if (s1_sat_min_q) mag = MAG_ONE;
    mag_neg  = ~mag + MAG_ONE;
    if (s1_inf_q) begin
      result_d = {1'b1, {(NBITS-1){1'b0}}};
    end else if (s1_zero_q) begin
      result_d = '0;
    end else begin
      result_d = {s1_sgn_q, s1_sgn_q ? mag_neg : mag};
    end
  end

  // Control path: valid bits and visible outputs are cleared by reset so that
  // in-flight operations are dropped and the outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      inf        <= 1'b0;
      zero       <= 1'b0;
    end else begin
      s0_valid_q <= start;
      s1_valid_q <= s0_valid_q;
      done       <= s1_valid_q;
      result     <= result_d;
      inf        <= s1_inf_q;
      zero       <= s1_zero_q & ~s1_inf_q;
    end
  end

  // NOTE: the datapath registers carry no reset; their contents only matter
  // alongside a set valid bit, and leaving them unreset keeps the wide
  // pipeline free of reset fan-out.
  always_ff @(posedge clk) begin
    s0_vp_q      <= posit_es3_pkg::deserialize_prod(in);
    s1_kept_q    <= s1_kept_d;
    s1_guard_q   <= s1_guard_d;
    s1_sticky_q  <= s1_sticky_d;
    s1_sgn_q     <= s0_vp_q.sgn;
    s1_sat_max_q <= s1_sat_max_d;
    s1_sat_min_q <= s1_sat_min_d;
    s1_inf_q     <= s0_vp_q.inf;
    s1_zero_q    <= s0_vp_q.zero;
  end

endmodule
